// File: rtl/svc_soc_uart_capture_pkg.sv
// Purpose : shared types, FSM state encoding and baud-timing helpers for the UART capture block.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package svc_soc_uart_capture_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        RECOVER = 3'd4
    } state_t;

    // Clocks per bit, integer divide.
    function automatic int unsigned calc_cpb(input int unsigned clock_freq,
                                             input int unsigned baud_rate);
        return clock_freq / baud_rate;
    endfunction

    // Half a bit period: start-bit sample lands mid-bit.
    function automatic int unsigned calc_half(input int unsigned clock_freq,
                                              input int unsigned baud_rate);
        return calc_cpb(clock_freq, baud_rate) / 2;
    endfunction

endpackage

// File: rtl/svc_soc_uart_capture_if.sv
// Purpose : byte stream from the capture FIFO to its consumer.
// Latency : n/a (wires only).
// Backpressure: byte is held while m_valid && !m_ready; transfer on m_valid && m_ready.
// Ports   : m_valid/m_data driven by master, m_ready driven by slave.
interface svc_soc_uart_capture_if;
    import svc_soc_uart_capture_pkg::*;

    logic  m_valid;
    byte_t m_data;
    logic  m_ready;

    modport master (output m_valid, output m_data, input  m_ready);
    modport slave  (input  m_valid, input  m_data, output m_ready);
endinterface

// File: rtl/svc_soc_uart_capture_fifo.sv
// Purpose : synchronous byte FIFO with registered occupancy; head byte read from storage at rd pointer.
// Latency : push on edge n -> head visible (empty low) after edge n.
// Backpressure: push ignored while full unless a pop happens in the same cycle (slot is reused).
// Ports   : push/push_dat in, pop in, full/empty/head_dat out.
module svc_soc_uart_capture_fifo
    import svc_soc_uart_capture_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push,
    input  byte_t push_dat,
    input  logic  pop,
    output logic  full,
    output logic  empty,
    output byte_t head_dat
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    byte_t         mem_q [DEPTH];
    logic          do_push, do_pop;

    always_comb begin
        full     = (cnt_q == DEPTH_C);
        empty    = (cnt_q == '0);
        do_pop   = pop && !empty;
        // A pop in the same cycle frees the slot the write lands in, so full is no obstacle then.
        do_push  = push && (!full || do_pop);
        head_dat = empty ? '0 : mem_q[rd_ptr_q];

        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: head_dat is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end
endmodule

// File: rtl/svc_soc_uart_capture.sv
// Purpose : 8N1 UART receiver; synchronizes urx, deserializes frames, drops bad-stop frames, buffers good bytes.
// Latency : m_valid rises one cycle after the stop-bit sample (t0 + HALF + 9*CPB + 1, t0 = first low urx_s cycle).
// Backpressure: FIFO absorbs FIFO_DEPTH bytes; a good byte arriving while full (no pop) is dropped with an overflow pulse.
// Ports   : clk, rst_n, urx in; m (stream master); busy, frame_err, overflow out.
module svc_soc_uart_capture
    import svc_soc_uart_capture_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 25_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          urx,
    svc_soc_uart_capture_if.master        m,
    output logic                          busy,
    output logic                          frame_err,
    output logic                          overflow
);
    localparam int unsigned CPB  = calc_cpb(CLOCK_FREQ, BAUD_RATE);
    localparam int unsigned HALF = calc_half(CLOCK_FREQ, BAUD_RATE);
    localparam int          CW   = $clog2(CPB);
    // The counter is loaded with N-1 so that expiry (zero) lands exactly N cycles after entry.
    localparam logic [CW-1:0] CPB_RELOAD  = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_RELOAD = CW'(HALF - 1);

    logic [1:0]    sync_q,      sync_d;
    state_t        state_q,     state_d;
    logic [CW-1:0] cnt_q,       cnt_d;
    logic [2:0]    idx_q,       idx_d;
    byte_t         shift_q,     shift_d;
    logic          frame_err_q, frame_err_d;
    logic          overflow_q,  overflow_d;

    logic urx_s, expire, push, pop, fifo_full, fifo_empty;

    assign urx_s  = sync_q[1];
    assign expire = (cnt_q == '0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= 2'b11;
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    // Next state
    always_comb begin
        sync_d  = {sync_q[0], urx};
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        unique case (state_q)
            IDLE: begin
                if (!urx_s) begin
                    state_d = START;
                    cnt_d   = HALF_RELOAD;
                end
            end
            START: begin
                if (!expire) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (!urx_s) begin
                    state_d = DATA;
                    cnt_d   = CPB_RELOAD;
                    idx_d   = '0;
                end else begin
                    // Line went back high before mid-start-bit: treat as a glitch.
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (!expire) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    shift_d = {urx_s, shift_q[7:1]};
                    cnt_d   = CPB_RELOAD;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (!expire) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = urx_s ? IDLE : RECOVER;
                end
            end
            RECOVER: begin
                // A break or stuck-low line must not be mistaken for a fresh start bit.
                if (urx_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy        = (state_q != IDLE);
        push        = (state_q == STOP) && expire && urx_s;
        frame_err_d = (state_q == STOP) && expire && !urx_s;
        pop         = m.m_valid && m.m_ready;
        overflow_d  = push && fifo_full && !pop;
        frame_err   = frame_err_q;
        overflow    = overflow_q;
        m.m_valid   = !fifo_empty;
    end

    svc_soc_uart_capture_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (shift_q),
        .pop      (pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head_dat (m.m_data)
    );
endmodule

// File: tb/tb_svc_soc_uart_capture.sv
module tb_svc_soc_uart_capture;
    localparam int CLK_HZ = 25_000_000;
    localparam int BAUD   = 115_200;
    localparam int CPB    = CLK_HZ / BAUD;
    localparam int HALF   = CPB / 2;
    localparam int DEPTH  = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic urx   = 1'b1;
    logic busy, frame_err, overflow;

    svc_soc_uart_capture_if uif();

    svc_soc_uart_capture #(
        .CLOCK_FREQ (CLK_HZ),
        .BAUD_RATE  (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .urx       (urx),
        .m         (uif),
        .busy      (busy),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          passed = 0;
    int unsigned cyc    = 0;
    logic [7:0]  exp_q[$];
    int          exp_fe = 0, exp_ovf = 0, fe_cnt = 0, ovf_cnt = 0;
    int unsigned vld_rise_cyc = 0;
    int unsigned start_cyc = 0;
    logic        vld_prev  = 1'b0;
    logic        busy_seen = 1'b0;
    int          rdy_mode  = 0;   // 0: hold low, 1: hold high, 2: random

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       uif.m_ready = 1'b0;
            1:       uif.m_ready = 1'b1;
            default: uif.m_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: pops the scoreboard on every accepted byte and counts pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (uif.m_valid && !vld_prev) vld_rise_cyc = cyc;
            if (busy) busy_seen = 1'b1;
            if (frame_err) fe_cnt++;
            if (overflow) ovf_cnt++;
            if (uif.m_valid && uif.m_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_byte: got %02h, expected nothing (cycle %0d)", uif.m_data, cyc);
                end else begin
                    check("byte", {24'd0, uif.m_data}, {24'd0, exp_q.pop_front()});
                end
            end
        end
        vld_prev = rst_n ? uif.m_valid : 1'b0;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        urx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    // Reference model: a good frame becomes a byte unless DEPTH bytes are already waiting.
    task automatic send_frame(input logic [7:0] b, input logic stop_v);
        if (stop_v) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(b);
            else exp_ovf++;
        end else begin
            exp_fe++;
        end
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_v);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || uif.m_valid) && n < 4 * CPB) begin
            step(1);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        #(100_000 * 10);
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        step(4);
        check("rst_m_valid",   uif.m_valid, 0);
        check("rst_m_data",    uif.m_data,  0);
        check("rst_busy",      busy,        0);
        check("rst_frame_err", frame_err,   0);
        check("rst_overflow",  overflow,    0);
        rst_n = 1'b1;
        step(10);

        // Single frame, exact m_valid rise cycle
        rdy_mode = 0;
        send_frame(8'h55, 1'b1);
        check("rise_cycle", vld_rise_cyc, start_cyc + 3 + HALF + 9 * CPB);
        rdy_mode = 1;
        drain("drain_55");
        check("fe_after_55", fe_cnt, exp_fe);
        check("ovf_after_55", ovf_cnt, exp_ovf);

        // Back-to-back frames with consumer always ready
        send_frame(8'hA3, 1'b1);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        drain("drain_b2b");

        // Short low glitch
        step(5);
        busy_seen = 1'b0;
        urx = 1'b0;
        step(40);
        urx = 1'b1;
        step(HALF + 20);
        check("glitch_busy_seen", busy_seen, 1);
        check("glitch_idle", busy, 0);
        check("glitch_no_byte", uif.m_valid, 0);
        check("glitch_no_fe", fe_cnt, exp_fe);

        // Bad stop bit, stuck-low line, then recovery
        send_frame(8'h3C, 1'b0);
        step(5 * CPB);
        check("recover_busy", busy, 1);
        check("recover_fe_cnt", fe_cnt, exp_fe);
        check("recover_no_byte", uif.m_valid, 0);
        urx = 1'b1;
        step(6);
        check("recover_exit", busy, 0);
        send_frame(8'h41, 1'b1);
        drain("drain_41");

        // Overflow: 17 bytes into a 16-deep FIFO with the consumer stalled
        rdy_mode = 0;
        step(3);
        for (int i = 0; i <= DEPTH; i++) send_frame(8'(i), 1'b1);
        check("ovf_cnt", ovf_cnt, exp_ovf);
        check("full_valid", uif.m_valid, 1);
        rdy_mode = 1;
        drain("drain_full");

        // Random bytes against a random consumer
        rdy_mode = 2;
        repeat (3) send_frame(8'($urandom_range(0, 255)), 1'b1);
        drain("drain_rand");

        // Reset mid-frame with bytes buffered
        rdy_mode = 0;
        step(3);
        repeat (3) send_frame(8'($urandom_range(0, 255)), 1'b1);
        check("pre_rst_valid", uif.m_valid, 1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_m_valid", uif.m_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_m_data", uif.m_data, 0);
        exp_q.delete();
        urx = 1'b1;
        step(3);
        rst_n = 1'b1;
        step(5);
        check("post_rst_valid", uif.m_valid, 0);
        rdy_mode = 1;
        send_frame(8'h7E, 1'b1);
        drain("drain_7e");

        check("final_fe_cnt", fe_cnt, exp_fe);
        check("final_ovf_cnt", ovf_cnt, exp_ovf);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
